storebuf_drain_sched: RTL
=========================

# storebuf_drain_sched

Committed-store buffer and write-port scheduler for the data memory. Accepts up to two committed stores per cycle from the commit stage, holds them in order in a circular queue, and drains up to two per cycle onto the data memory's two write ports (dwaddr/dwdata/dwsize/dwe). It guarantees in-order, hazard-free use of the sub-word merge path.

## Interface
- ENTRY_NUM, 4, queue depth; power of two, at least 2
- ADDR_LEN, 32, address width
- DATA_LEN, 32, data width
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all state
- push1, push2  in  1  store valid; push1 is older than push2
- paddr1, paddr2  in  ADDR_LEN  store byte address
- pdata1, pdata2  in  DATA_LEN  store data, right-aligned
- psize1, psize2  in  2  size code: 0 = byte, 1 = half, 2 = word; 3 is illegal
- full  out  1  asserted when free entries < 2
- empty  out  1  asserted when count == 0
- count  out  $clog2(ENTRY_NUM)+1  occupied entries
- err  out  1  sticky; set by a dropped push or an illegal size
- drain_en  in  1  permits writes this cycle (low while loads have priority)
- dwe1, dwe2  out  1  write enables to memory ports 1 and 2
- dwaddr1, dwaddr2  out  ADDR_LEN  write addresses
- dwdata1, dwdata2  out  DATA_LEN  write data
- dwsize1, dwsize2  out  2  write size codes
- ldaddr  in  ADDR_LEN  load address for the forwarding lookup
- fwd_hit  out  1  forwarding hit
- fwd_conflict  out  1  forwarding conflict
- fwd_data  out  DATA_LEN  forwarded data

## Operation
- Storage is a circular queue of {addr, data, size} entries with head pointer, tail pointer and count registers. Pointers wrap modulo ENTRY_NUM.
- **Push**
  - Accepted pushes are written at the tail in order push1, push2.
  - If only push2 is valid, it takes a single slot.
  - Pushes arriving while `full` is registered high are dropped and set `err`.
  - A push with size 3 is dropped and sets `err`. Its companion push is still accepted.
- **Drain outputs** are combinational from registered state.
  - `dwe1` = drain_en && count ≥ 1. Port 1 carries the head entry.
  - `dwe2` = drain_en && count ≥ 2 && word(head+1) ≠ word(head), where word(a) = a[ADDR_LEN-1:2]. Port 2 carries the head+1 entry.
  - A same-word pair drains one entry per cycle. This is required because both ports merge against the pre-edge memory word.
  - When `dwe` is low, the corresponding addr/data/size outputs are 0.
- **Head and count update:** head advances by the number of asserted `dwe`. count = count + accepted − drained. Push and drain in the same cycle are legal, including when count == ENTRY_NUM−1.
- **Forwarding:** see Configuration.
- **State machine:** none beyond the queue. Its effective states are EMPTY (count=0), PARTIAL, and FULL (free < 2); transitions follow count only.

## Timing
- Reset values: count=0, head=tail=0, empty=1, full=0, err=0, all dwe*=0, all dw*=0, fwd_hit=fwd_conflict=0, fwd_data=0.
- A push sampled at edge N is visible at the head no earlier than after edge N, so the earliest memory write is at edge N+1. Minimum push-to-memory latency is 1 cycle.
- `full`, `empty` and `count` are registered and reflect the state after the last edge.
- Reset asserted mid-operation discards all entries immediately; stores already drained remain in memory.
- Forwarding outputs are combinational from ldaddr and queue state in the same cycle.

## Configuration
- `STBUF_FWD_EN` defined:
  - Scan valid entries youngest-first for the first entry with word(addr) == word(ldaddr).
  - If that entry is word-size with addr[1:0]=0: fwd_hit=1, fwd_data=its data.
  - If it is sub-word: fwd_conflict=1 and fwd_hit=0; the load must retry.
  - If no entry matches: both outputs are 0.
- `STBUF_FWD_EN` undefined: forwarding ports remain present; fwd_hit, fwd_conflict and fwd_data are tied to 0 and no compare logic is built.

## Test plan
- Reset, then push1 {0x100, 0xDEADBEEF, word} with drain_en=1 → dwe1=1, dwaddr1=0x100, dwdata1=0xDEADBEEF the next cycle; empty=1 after the following edge.
- Dual push {0x200, byte 0xAA} + {0x204, word 0x11223344}, drain_en=1 → both ports fire in the same cycle, dwe1=dwe2=1, count returns to 0.
- Dual push {0x300, byte} + {0x301, byte}, same word → cycle 1: dwe1=1, dwe2=0; cycle 2: dwe1=1 carrying 0x301.
- drain_en=0, push 2 per cycle → full=1 when count ≥ 3 (ENTRY_NUM=4); a further push is dropped and err=1; tail wraps correctly after draining.
- With STBUF_FWD_EN: queue {0x400 word 0x5}, then {0x400 word 0x9}; ldaddr=0x400 → fwd_hit=1, fwd_data=0x9. Then push {0x402 half}; ldaddr=0x400 → fwd_conflict=1, fwd_hit=0.
- Reset asserted with 3 entries queued → count=0, empty=1, dwe1=dwe2=0 immediately; no writes after release until a new push.

Source files
------------

// File: rtl/storebuf_drain_sched.sv
// storebuf_drain_sched
//
// Committed-store buffer and write-port scheduler for the data memory.
// Up to two committed stores are accepted per cycle and kept in order in a
// circular queue. Up to two stores drain per cycle onto the two memory write
// ports. Two stores that fall in the same 32-bit word never drain together,
// because both ports merge against the pre-edge memory word.
//
// Optional feature macro: STBUF_FWD_EN
//   When defined, a youngest-first store-to-load forwarding lookup is built.
//   When undefined, fwd_hit, fwd_conflict and fwd_data are tied to 0.
//
// Ports
//   clk, reset               clock; asynchronous active-high reset
//   push1/2, paddr1/2,
//   pdata1/2, psize1/2       committed stores (push1 older than push2)
//   full, empty, count, err  queue status; err is sticky
//   drain_en                 permits memory writes this cycle
//   dwe1/2, dwaddr1/2,
//   dwdata1/2, dwsize1/2     memory write ports (port 1 = head entry)
//   ldaddr                   load address for forwarding lookup
//   fwd_hit, fwd_conflict,
//   fwd_data                 forwarding result

module storebuf_drain_sched #(
  parameter int ENTRY_NUM = 4,
  parameter int ADDR_LEN  = 32,
  parameter int DATA_LEN  = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push1,
  input  logic                         push2,
  input  logic [ADDR_LEN-1:0]          paddr1,
  input  logic [ADDR_LEN-1:0]          paddr2,
  input  logic [DATA_LEN-1:0]          pdata1,
  input  logic [DATA_LEN-1:0]          pdata2,
  input  logic [1:0]                   psize1,
  input  logic [1:0]                   psize2,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(ENTRY_NUM):0]   count,
  output logic                         err,
  input  logic                         drain_en,
  output logic                         dwe1,
  output logic                         dwe2,
  output logic [ADDR_LEN-1:0]          dwaddr1,
  output logic [ADDR_LEN-1:0]          dwaddr2,
  output logic [DATA_LEN-1:0]          dwdata1,
  output logic [DATA_LEN-1:0]          dwdata2,
  output logic [1:0]                   dwsize1,
  output logic [1:0]                   dwsize2,
  input  logic [ADDR_LEN-1:0]          ldaddr,
  output logic                         fwd_hit,
  output logic                         fwd_conflict,
  output logic [DATA_LEN-1:0]          fwd_data
);

  localparam int PTR_W = $clog2(ENTRY_NUM);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_LEN-1:0] addr_q [ENTRY_NUM];
  logic [DATA_LEN-1:0] data_q [ENTRY_NUM];
  logic [1:0]          size_q [ENTRY_NUM];

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [PTR_W-1:0] headNext, wrPtr2;
  logic [CNT_W-1:0] count_q, count_d, numAcc, numDrn;
  logic             err_q, err_d;
  logic             acc1, acc2, fullInt;

  // Full means fewer than two free slots, so a dual push can always land.
  assign fullInt  = (count_q >= CNT_W'(ENTRY_NUM - 1));
  assign full     = fullInt;
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign err      = err_q;
  assign headNext = head_q + PTR_W'(1);

  // Same-word pairs drain one per cycle: both ports merge against the old word.
  assign dwe1 = drain_en && (count_q != '0);
  assign dwe2 = drain_en && (count_q >= CNT_W'(2)) &&
                (addr_q[headNext][ADDR_LEN-1:2] != addr_q[head_q][ADDR_LEN-1:2]);

  assign dwaddr1 = dwe1 ? addr_q[head_q]   : '0;
  assign dwdata1 = dwe1 ? data_q[head_q]   : '0;
  assign dwsize1 = dwe1 ? size_q[head_q]   : '0;
  assign dwaddr2 = dwe2 ? addr_q[headNext] : '0;
  assign dwdata2 = dwe2 ? data_q[headNext] : '0;
  assign dwsize2 = dwe2 ? size_q[headNext] : '0;

  // Push acceptance and pointer/count bookkeeping. A dropped push1 lets
  // push2 take the tail slot itself so the queue stays dense.
  always_comb begin
    acc1    = push1 && !fullInt && (psize1 != 2'd3);
    acc2    = push2 && !fullInt && (psize2 != 2'd3);
    err_d   = err_q ||
              (push1 && (fullInt || (psize1 == 2'd3))) ||
              (push2 && (fullInt || (psize2 == 2'd3)));
    numAcc  = CNT_W'(acc1) + CNT_W'(acc2);
    numDrn  = CNT_W'(dwe1) + CNT_W'(dwe2);
    count_d = count_q + numAcc - numDrn;
    head_d  = head_q + numDrn[PTR_W-1:0];
    tail_d  = tail_q + numAcc[PTR_W-1:0];
    wrPtr2  = tail_q + PTR_W'(acc1);
  end

  // Queue storage and control registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < ENTRY_NUM; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        size_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_q   <= err_d;
      if (acc1) begin
        addr_q[tail_q] <= paddr1;
        data_q[tail_q] <= pdata1;
        size_q[tail_q] <= psize1;
      end
      if (acc2) begin
        addr_q[wrPtr2] <= paddr2;
        data_q[wrPtr2] <= pdata2;
        size_q[wrPtr2] <= psize2;
      end
    end
  end

`ifdef STBUF_FWD_EN
  logic [PTR_W-1:0] fwdSlot;

  // Walk oldest to youngest; a later match overrides, so the youngest wins.
  // Anything other than an aligned word store can only partly cover the load.
  always_comb begin
    fwd_hit      = 1'b0;
    fwd_conflict = 1'b0;
    fwd_data     = '0;
    fwdSlot      = head_q;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      fwdSlot = head_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) &&
          (addr_q[fwdSlot][ADDR_LEN-1:2] == ldaddr[ADDR_LEN-1:2])) begin
        if ((size_q[fwdSlot] == 2'd2) && (addr_q[fwdSlot][1:0] == 2'b00)) begin
          fwd_hit      = 1'b1;
          fwd_conflict = 1'b0;
          fwd_data     = data_q[fwdSlot];
        end else begin
          fwd_hit      = 1'b0;
          fwd_conflict = 1'b1;
          fwd_data     = '0;
        end
      end
    end
  end
`else
  logic ldaddr_unused;

  assign ldaddr_unused = ^ldaddr;
  assign fwd_hit       = 1'b0;
  assign fwd_conflict  = 1'b0;
  assign fwd_data      = '0;
`endif

endmodule
